// File: rtl/cla_subtractor_seq.sv
// -----------------------------------------------------------------------------
// cla_subtractor_seq
//   Multi-cycle borrow-lookahead subtractor. Computes Diff = A - B - b_in one
//   4-bit nibble per clock, LSB nibble first. The nibble borrow-out is
//   registered and chained into the next nibble. A start/busy/done handshake
//   connects it to the control unit, and it produces borrow, zero, negative
//   and signed-overflow flags for the flags register.
//
// Optional feature macro: SUB_SATURATE_EN
//   When defined, unsigned saturation is applied. A final borrow of 1 clamps
//   Diff to 0, so zero=1 and neg=0. b_out and ovf still describe the
//   unclamped result. When undefined, Diff is the wrapped result.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request, honoured in IDLE or DONE
//   b_in   in   borrow-in, latched on accepted start
//   A      in   [WIDTH] minuend, latched on accepted start
//   B      in   [WIDTH] subtrahend, latched on accepted start
//   busy   out  high while nibbles are being processed
//   done   out  one-cycle pulse when the result registers are valid
//   Diff   out  [WIDTH] registered difference, held until next completion
//   b_out  out  final borrow-out (unsigned A < B + b_in)
//   zero   out  Diff == 0
//   neg    out  Diff[WIDTH-1]
//   ovf    out  signed overflow of the unclamped difference
// -----------------------------------------------------------------------------
module cla_subtractor_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             b_in,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Diff,
   output logic             b_out,
   output logic             zero,
   output logic             neg,
   output logic             ovf
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam int MSB     = WIDTH - 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   b_r;
   logic [WIDTH-1:0]   acc;        // nibbles completed so far
   logic               borrow_r;   // borrow into the current nibble
   logic [IDX_W-1:0]   idx;

   logic [3:0]         nib_a;
   logic [3:0]         nib_b;
   logic [4:0]         nib_res;    // {borrow_out, diff_nibble}
   logic [WIDTH-1:0]   raw_diff;   // acc with the current nibble merged in
   logic [WIDTH-1:0]   final_diff;
   logic               last_nib;

   // One nibble of borrow lookahead: every borrow is a flat sum of products of
   // generate/propagate terms and the incoming borrow, with no ripple.
   function automatic logic [4:0] nib_sub(input logic [3:0] a,
                                          input logic [3:0] b,
                                          input logic       bi);
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] br;
      g     = ~a & b;
      p     = ~a | b;
      br[0] = bi;
      br[1] = g[0] | (p[0] & bi);
      br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
      br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & bi);
      br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]) | (&p & bi);
      return {br[4], a ^ b ^ br[3:0]};
   endfunction

`ifdef SUB_SATURATE_EN
   // A final borrow means the unsigned result went below zero, so clamp it.
   function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                 input logic             borrow);
      return borrow ? '0 : raw;
   endfunction
`endif

   always_comb begin
      nib_a    = '0;
      nib_b    = '0;
      raw_diff = acc;
      for (int n = 0; n < NIBBLES; n++) begin
         if (int'(idx) == n) begin
            nib_a = a_r[n*4 +: 4];
            nib_b = b_r[n*4 +: 4];
         end
      end
      nib_res = nib_sub(nib_a, nib_b, borrow_r);
      for (int n = 0; n < NIBBLES; n++) begin
         if (int'(idx) == n) begin
            raw_diff[n*4 +: 4] = nib_res[3:0];
         end
      end
      last_nib = (int'(idx) == NIBBLES - 1);
   end

`ifdef SUB_SATURATE_EN
   assign final_diff = saturate(raw_diff, nib_res[4]);
`else
   assign final_diff = raw_diff;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         a_r      <= '0;
         b_r      <= '0;
         acc      <= '0;
         borrow_r <= 1'b0;
         idx      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         Diff     <= '0;
         b_out    <= 1'b0;
         zero     <= 1'b0;
         neg      <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         case (state)
            // IDLE and DONE both accept a new request, giving back-to-back ops.
            ST_IDLE, ST_DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_r      <= A;
                  b_r      <= B;
                  borrow_r <= b_in;
                  acc      <= '0;
                  idx      <= '0;
                  busy     <= 1'b1;
                  state    <= ST_RUN;
               end else begin
                  state    <= ST_IDLE;
               end
            end
            ST_RUN: begin
               acc      <= raw_diff;
               borrow_r <= nib_res[4];
               if (last_nib) begin
                  // Result registers only change here, so Diff never shows a
                  // partially computed value.
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  idx   <= '0;
                  Diff  <= final_diff;
                  b_out <= nib_res[4];
                  zero  <= (final_diff == '0);
                  neg   <= final_diff[MSB];
                  ovf   <= (a_r[MSB] != b_r[MSB]) && (raw_diff[MSB] != a_r[MSB]);
               end else begin
                  idx   <= idx + IDX_W'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/cla_subtractor_seq.md
Name: cla_subtractor_seq

Overview:
- Multi-cycle borrow-lookahead subtractor for the 8-bit datapath: the subtract counterpart to the nibble carry-lookahead adder.
- Computes Diff = A - B - b_in, one 4-bit nibble per clock, LSB nibble first, with the borrow chained between nibbles.
- Sits beside the adder in the ALU; driven by the control unit through a start/busy/done handshake.
- Produces borrow, zero, negative and signed-overflow flags for the flags register.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived nibble count (RUN cycles per operation); not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled in IDLE or DONE only.
- b_in  input  1  borrow-in, latched on accepted start.
- A  input  WIDTH  minuend, latched on accepted start.
- B  input  WIDTH  subtrahend, latched on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result is valid.
- Diff  output  WIDTH  registered difference; holds until the next completion.
- b_out  output  1  final borrow-out (unsigned A < B + b_in).
- zero  output  1  Diff == 0.
- neg  output  1  Diff[WIDTH-1].
- ovf  output  1  signed overflow: A[MSB] != B[MSB] and raw Diff[MSB] != A[MSB].

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE, nibble index 0, all internal registers 0. Outputs during reset: busy=0, done=0, Diff=0, b_out=0, zero=0, neg=0, ovf=0.
- States:
  - IDLE: start=1 latches A, B, b_in; clears index; goes to RUN.
  - RUN: each edge processes nibble[index]; index increments; after NIBBLES edges goes to DONE.
  - DONE: done=1 for exactly this cycle. start=1 here is accepted (back-to-back, same as IDLE); otherwise goes to IDLE.
- Nibble logic, bit i:
  - g = ~a & b; p = ~a | b.
  - borrow[i+1] = g | (p & borrow[i]).
  - d = a ^ b ^ borrow[i].
  - Nibble borrow-out is registered and feeds the next nibble; nibble 0 uses latched b_in.
- Latency: with start accepted at edge k, done is high in the cycle after edge k+NIBBLES (2 cycles for WIDTH=8). Throughput is one operation per NIBBLES+1 cycles.
- Result registers (Diff, b_out, zero, neg, ovf) update only on the RUN->DONE edge; partial nibbles never appear on Diff.
- start during RUN is ignored; no queuing. Operand changes after acceptance have no effect.
- Reset mid-operation aborts the operation and discards the partial result; the first start after reset release is accepted normally.

Optional Feature:
- Macro SUB_SATURATE_EN.
- Defined: unsigned saturation. If the final borrow is 1, Diff loads 0, zero=1, neg=0. b_out and ovf are still computed from the unclamped result.
- Undefined: Diff is the wrapped modulo-2^WIDTH result; no clamping logic is present.

Test Plan (WIDTH=8):
- A=0x5A, B=0x23, b_in=0, start pulse -> 2 cycles later done=1 for one cycle; Diff=0x37, b_out=0, zero=0, neg=0, ovf=0; busy=1 during the 2 RUN cycles.
- A=0x00, B=0x01, b_in=0 -> Diff=0xFF, b_out=1, neg=1, ovf=0 (borrow crosses the nibble boundary). A=0x10, B=0x20 -> Diff=0xF0, b_out=1.
- A=0x80, B=0x01 -> Diff=0x7F, ovf=1, neg=0, b_out=0. A=0x42, B=0x41, b_in=1 -> Diff=0x00, zero=1, b_out=0.
- start held high continuously, A changed mid-RUN -> changes ignored; done pulses every 3 cycles; each result matches the operands latched at its own acceptance.
- rst_n driven low during the first RUN cycle -> busy and all outputs go to 0 immediately, no done pulse. After release, A=0x05, B=0x03 -> Diff=0x02.
- SUB_SATURATE_EN defined: A=0x10, B=0x20 -> Diff=0x00, zero=1, neg=0, b_out=1. Undefined: same stimulus -> Diff=0xF0.
